// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_t;

    localparam int unsigned CAUSE_POR_BIT = 0;

    function automatic int unsigned cause_src_bit(input int unsigned idx);
        return idx + 1;
    endfunction

    function automatic int unsigned cause_sw_bit(input int unsigned num_src);
        return num_src + 1;
    endfunction

    function automatic int unsigned cause_wdog_bit(input int unsigned num_src);
        return num_src + 2;
    endfunction

    // Bits needed to hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_src_conditioner.sv
// One reset source: synchroniser, debounce filter and edge/level qualifier.
module reset_src_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          FALL_MODE       = 1'b1
) (
    input  logic CLK,
    input  logic reset_in,
    input  logic src_async,
    output logic trig
);
    import reset_seq_pkg::*;

    localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   db_level;
    logic                   db_prev;
    logic [DB_W-1:0]        db_cnt;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or posedge reset_in) begin
        if (reset_in) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src_async};
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge CLK or posedge reset_in) begin
        if (reset_in) begin
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
            trig     <= 1'b0;
        end else begin
            if (synced != db_level) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_level <= synced;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
            db_prev <= db_level;
            trig    <= FALL_MODE ? (db_prev & ~db_level) : db_level;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset sequencer with sticky cause word.
// Optional watchdog trigger enabled by defining RSTSEQ_WDOG_EN.
module reset_sequencer #(
    parameter int unsigned         NUM_SRC         = 2,
    parameter logic [NUM_SRC-1:0]  SRC_MODE        = NUM_SRC'(1),
    parameter int unsigned         SYNC_STAGES     = 2,
    parameter int unsigned         DEBOUNCE_CYCLES = 4,
    parameter int unsigned         STRETCH_CYCLES  = 8,
    parameter int unsigned         NUM_OUT         = 3,
    parameter int unsigned         RELEASE_GAP     = 2,
    parameter int unsigned         WDOG_CYCLES     = 1024
) (
    input  logic                 CLK,
    input  logic                 reset_in,
    input  logic [NUM_SRC-1:0]   src_in,
    input  logic                 sw_reset_req,
    input  logic                 wdog_kick,
    output logic [NUM_OUT-1:0]   rst_out,
    output logic                 all_released,
    output logic [NUM_SRC+2:0]   reset_cause
);
    import reset_seq_pkg::*;

    localparam int unsigned CW       = NUM_SRC + 3;
    localparam int unsigned SRC_LO   = cause_src_bit(0);
    localparam int unsigned SW_BIT   = cause_sw_bit(NUM_SRC);
    localparam int unsigned WDOG_BIT = cause_wdog_bit(NUM_SRC);
    localparam int unsigned STR_W    = cnt_width(STRETCH_CYCLES);
    localparam int unsigned GAP_W    = cnt_width(RELEASE_GAP);
    localparam int unsigned IDX_W    = cnt_width(NUM_OUT);
    localparam logic [NUM_OUT-1:0] ALL_ON  = '1;
    localparam logic [NUM_OUT-1:0] ONE_HOT = NUM_OUT'(1);
    localparam logic [CW-1:0]      POR_CAUSE = CW'(1) << CAUSE_POR_BIT;

    seq_state_t         state;
    logic [STR_W-1:0]   str_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [IDX_W-1:0]   rel_idx;
    logic [NUM_SRC-1:0] src_trig;
    logic               wdog_trig;
    logic [CW-1:0]      trig_bits_c;
    logic               any_trig_c;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        reset_src_conditioner #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .FALL_MODE       (SRC_MODE[i])
        ) u_cond (
            .CLK       (CLK),
            .reset_in  (reset_in),
            .src_async (src_in[i]),
            .trig      (src_trig[i])
        );
    end

`ifdef RSTSEQ_WDOG_EN
    localparam int unsigned WD_W = cnt_width(WDOG_CYCLES);
    logic [WD_W-1:0] wdog_cnt;

    // Watchdog only counts while the system is running.
    always_ff @(posedge CLK or posedge reset_in) begin
        if (reset_in) begin
            wdog_cnt <= '0;
        end else if ((state != RUN) || wdog_kick || wdog_trig) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + WD_W'(1);
        end
    end

    assign wdog_trig = (state == RUN) && !wdog_kick &&
                       (wdog_cnt == WD_W'(WDOG_CYCLES - 1));
`else
    logic unused_wdog;
    assign unused_wdog = wdog_kick ^ (WDOG_CYCLES == 0);
    assign wdog_trig   = 1'b0;
`endif

    always_comb begin
        trig_bits_c                    = '0;
        trig_bits_c[SRC_LO +: NUM_SRC] = src_trig;
        trig_bits_c[SW_BIT]            = sw_reset_req;
        trig_bits_c[WDOG_BIT]          = wdog_trig;
    end

    assign any_trig_c = |trig_bits_c;

    // Sequencer: stretch in ASSERT, staged release, then RUN until the next trigger.
    always_ff @(posedge CLK or posedge reset_in) begin
        if (reset_in) begin
            state        <= ASSERT;
            str_cnt      <= '0;
            gap_cnt      <= '0;
            rel_idx      <= '0;
            rst_out      <= ALL_ON;
            all_released <= 1'b0;
            reset_cause  <= POR_CAUSE;
        end else begin
            case (state)
                ASSERT: begin
                    rst_out      <= ALL_ON;
                    all_released <= 1'b0;
                    if (any_trig_c) begin
                        str_cnt     <= '0;
                        reset_cause <= reset_cause | trig_bits_c;
                    end else if (str_cnt == STR_W'(STRETCH_CYCLES - 1)) begin
                        str_cnt <= '0;
                        gap_cnt <= '0;
                        rel_idx <= IDX_W'(1);
                        rst_out <= ALL_ON << 1;
                        if (NUM_OUT == 1) begin
                            state        <= RUN;
                            all_released <= 1'b1;
                        end else begin
                            state <= RELEASE;
                        end
                    end else begin
                        str_cnt <= str_cnt + STR_W'(1);
                    end
                end
                RELEASE, RUN: begin
                    if (any_trig_c) begin
                        state        <= ASSERT;
                        str_cnt      <= '0;
                        rst_out      <= ALL_ON;
                        all_released <= 1'b0;
                        reset_cause  <= trig_bits_c;
                    end else if (state == RELEASE) begin
                        if (gap_cnt == GAP_W'(RELEASE_GAP - 1)) begin
                            gap_cnt <= '0;
                            rst_out <= rst_out & ~(ONE_HOT << rel_idx);
                            rel_idx <= rel_idx + IDX_W'(1);
                            if (rel_idx == IDX_W'(NUM_OUT - 1)) begin
                                state        <= RUN;
                                all_released <= 1'b1;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                end
                default: begin
                    state   <= ASSERT;
                    str_cnt <= '0;
                    rst_out <= ALL_ON;
                end
            endcase
        end
    end

endmodule
